wm_phase_timer: RTL and testbench

- Timing and sequencing engine for the washer controller's soak, wash, rinse and spin phases.
- The controller issues a one-cycle start with a phase code and a mode. This block then:
  - runs an optional water-fill segment,
  - counts down the phase duration on a prescaled time tick,
  - pauses while the lid is open,
  - returns a one-cycle done pulse.
- The cancel input aborts the phase.

---
 rtl/wm_phase_timer.sv | 191 +++++++++++++++++++
 tb/tb_wm_phase_timer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wm_phase_timer.sv
// Phase timing engine for the washer controller: optional water fill, prescaled
// countdown of the phase duration, lid pause, cancel abort and done pulse.
module wm_phase_timer #(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned CNT_W    = 12,
  parameter int unsigned FILL_T   = 10,
  parameter int unsigned SOAK_T   = 60,
  parameter int unsigned WASH_T   = 120,
  parameter int unsigned RINSE_T  = 60,
  parameter int unsigned SPIN_T   = 30
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       phase,
  input  logic [1:0]       mode,
  input  logic             lid,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             paused,
  output logic             water_intake,
  output logic [CNT_W-1:0] remaining
);

  localparam int unsigned PRE_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_SAT = (1 << CNT_W) - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_e;

  // Phase duration in ticks, saturated to the counter range; mode 0 behaves as normal.
  function automatic logic [CNT_W-1:0] dur_f(input logic [1:0] ph, input logic [1:0] md);
    int unsigned wide;
    wide = 0;
    case (ph)
      2'd0:    wide = (md == 2'd1) ? 0 : SOAK_T;
      2'd1:    wide = (md == 2'd3) ? 2 * WASH_T : WASH_T;
      2'd2:    wide = RINSE_T;
      default: wide = SPIN_T;
    endcase
    if (wide > CNT_SAT) wide = CNT_SAT;
    return CNT_W'(wide);
  endfunction

  state_e             state_q, state_d;
  logic               ret_fill_q, ret_fill_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [1:0]         phase_q, phase_d;
  logic [1:0]         mode_q, mode_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;
  logic               paused_q, paused_d;
  logic               water_q, water_d;
  logic               tick_c;
  logic [CNT_W-1:0]   start_dur_c;

  assign tick_c      = (pre_q == PRE_W'(TICK_DIV - 1));
  assign start_dur_c = dur_f(phase, mode);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ret_fill_q <= 1'b0;
      pre_q      <= '0;
      rem_q      <= '0;
      phase_q    <= '0;
      mode_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      paused_q   <= 1'b0;
      water_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_fill_q <= ret_fill_d;
      pre_q      <= pre_d;
      rem_q      <= rem_d;
      phase_q    <= phase_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      paused_q   <= paused_d;
      water_q    <= water_d;
    end
  end

  // Next state: cancel beats lid, lid beats the tick, so pause entry never advances time.
  always_comb begin
    state_d    = state_q;
    ret_fill_d = ret_fill_q;
    pre_d      = pre_q;
    rem_d      = rem_q;
    phase_d    = phase_q;
    mode_d     = mode_q;
    aborted_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !lid && !cancel) begin
          phase_d = phase;
          mode_d  = mode;
          pre_d   = '0;
          if (start_dur_c == '0) begin
            state_d = ST_DONE;
            rem_d   = '0;
          end else if (phase != 2'd3) begin
            state_d = ST_FILL;
            rem_d   = CNT_W'(FILL_T);
          end else begin
            state_d = ST_RUN;
            rem_d   = start_dur_c;
          end
        end
      end

      ST_FILL, ST_RUN: begin
        if (cancel) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
          rem_d     = '0;
          pre_d     = '0;
        end else if (lid) begin
          state_d    = ST_PAUSE;
          ret_fill_d = (state_q == ST_FILL);
        end else if (tick_c) begin
          pre_d = '0;
          if (rem_q == CNT_W'(1)) begin
            if (state_q == ST_FILL) begin
              state_d = ST_RUN;
              rem_d   = dur_f(phase_q, mode_q);
            end else begin
              state_d = ST_DONE;
              rem_d   = '0;
            end
          end else begin
            rem_d = rem_q - CNT_W'(1);
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end

      ST_PAUSE: begin
        if (cancel) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
          rem_d     = '0;
          pre_d     = '0;
        end else if (!lid) begin
          state_d = ret_fill_q ? ST_FILL : ST_RUN;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        rem_d   = '0;
        pre_d   = '0;
      end
    endcase
  end

  // Status outputs are registered alongside the state they describe.
  always_comb begin
    busy_d   = (state_d == ST_FILL) || (state_d == ST_RUN) || (state_d == ST_PAUSE);
    done_d   = (state_d == ST_DONE);
    paused_d = (state_d == ST_PAUSE);
    water_d  = (state_d == ST_FILL);
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;
  assign paused       = paused_q;
  assign water_intake = water_q;
  assign remaining    = rem_q;

endmodule

// File: tb/tb_wm_phase_timer.sv
// Scenario bench for wm_phase_timer: done/aborted events go through an expected-event
// queue; per-cycle status outputs are checked inline against a small remaining model.
module tb_wm_phase_timer;

  localparam int unsigned TD = 4;
  localparam int unsigned CW = 12;
  localparam int unsigned FT = 2;
  localparam int unsigned ST = 5;
  localparam int unsigned WT = 3;
  localparam int unsigned RT = 4;
  localparam int unsigned PT = 2;
  localparam int unsigned SAT = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start, s_start;
  logic [1:0]    phase, mode;
  logic          lid, cancel;
  logic          busy, done, aborted, paused, water_intake;
  logic [CW-1:0] remaining;
  logic          s_busy, s_done, s_aborted, s_paused, s_water_intake;
  logic [CW-1:0] s_remaining;

  typedef struct {
    bit is_done;
    int at;
  } ev_t;

  ev_t exp_q[$];
  ev_t ev;
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  wm_phase_timer #(
    .TICK_DIV(TD), .CNT_W(CW), .FILL_T(FT), .SOAK_T(ST),
    .WASH_T(WT), .RINSE_T(RT), .SPIN_T(PT)
  ) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start), .phase(phase), .mode(mode),
    .lid(lid), .cancel(cancel), .busy(busy), .done(done), .aborted(aborted),
    .paused(paused), .water_intake(water_intake), .remaining(remaining)
  );

  wm_phase_timer #(
    .TICK_DIV(TD), .CNT_W(CW), .FILL_T(FT), .SOAK_T(ST),
    .WASH_T(SAT), .RINSE_T(RT), .SPIN_T(PT)
  ) u_sat (
    .clock(clock), .reset_n(reset_n), .start(s_start), .phase(phase), .mode(mode),
    .lid(lid), .cancel(cancel), .busy(s_busy), .done(s_done), .aborted(s_aborted),
    .paused(s_paused), .water_intake(s_water_intake), .remaining(s_remaining)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard: every done/aborted pulse must match the next expected event.
  always @(negedge clock) begin
    if (reset_n && (done || aborted)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d done=%0b aborted=%0b", cyc, done, aborted);
      end else begin
        ev = exp_q.pop_front();
        if (ev.at != cyc || ev.is_done != done || (done && aborted)) begin
          errors++;
          $display("FAIL event cyc=%0d done=%0b aborted=%0b want cyc=%0d done=%0b",
                   cyc, done, aborted, ev.at, ev.is_done);
        end
      end
    end
  end

  // Expected remaining at relative cycle k after a start (k=1 first cycle after start).
  function automatic int exp_rem(int k, bit fill, int d);
    int fc;
    fc = fill ? int'(FT * TD) : 0;
    if (k < 1) return 0;
    if (k <= fc) return int'(FT) - (k - 1) / int'(TD);
    if (k <= fc + d * int'(TD)) return d - (k - 1 - fc) / int'(TD);
    return 0;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; s_start = 1'b0; phase = '0; mode = '0;
    lid = 1'b0; cancel = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, done, aborted, paused, water_intake} !== 5'b0 || remaining !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b rem=%0d want 00000 rem=0",
               {busy, done, aborted, paused, water_intake}, remaining);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || remaining !== '0) begin
      errors++;
      $display("FAIL post_reset_idle busy=%0b rem=%0d want 0 0", busy, remaining);
    end
  endtask

  task automatic test_wash_fill();
    int c0;
    @(negedge clock);
    c0 = cyc; phase = 2'd1; mode = 2'd2; start = 1'b1;
    exp_q.push_back('{1'b1, c0 + 21});
    for (int k = 1; k <= 24; k++) begin
      @(negedge clock);
      start = 1'b0;
      checks++;
      if (water_intake !== 1'(k <= 8)) begin
        errors++; $display("FAIL wash_water k=%0d got %0b want %0b", k, water_intake, k <= 8);
      end
      checks++;
      if (busy !== 1'(k <= 20)) begin
        errors++; $display("FAIL wash_busy k=%0d got %0b want %0b", k, busy, k <= 20);
      end
      checks++;
      if (int'(remaining) !== exp_rem(k, 1'b1, 3)) begin
        errors++;
        $display("FAIL wash_remaining k=%0d got %0d want %0d", k, remaining, exp_rem(k, 1'b1, 3));
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL wash_pending got %0d want 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_spin_and_zero();
    int c0;
    @(negedge clock);
    c0 = cyc; phase = 2'd3; mode = 2'd2; start = 1'b1;
    exp_q.push_back('{1'b1, c0 + 9});
    for (int k = 1; k <= 11; k++) begin
      @(negedge clock);
      start = 1'b0;
      checks++;
      if (water_intake !== 1'b0 || busy !== 1'(k <= 8)) begin
        errors++;
        $display("FAIL spin_status k=%0d water=%0b busy=%0b want 0 %0b", k, water_intake, busy, k <= 8);
      end
      checks++;
      if (int'(remaining) !== exp_rem(k, 1'b0, 2)) begin
        errors++;
        $display("FAIL spin_remaining k=%0d got %0d want %0d", k, remaining, exp_rem(k, 1'b0, 2));
      end
    end
    @(negedge clock);
    c0 = cyc; phase = 2'd0; mode = 2'd1; start = 1'b1;
    exp_q.push_back('{1'b1, c0 + 1});
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || water_intake !== 1'b0 || remaining !== '0) begin
        errors++;
        $display("FAIL soak_quick k=%0d busy=%0b water=%0b rem=%0d want 0 0 0",
                 k, busy, water_intake, remaining);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL spin_pending got %0d want 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_pause();
    int c0, er;
    @(negedge clock);
    c0 = cyc; phase = 2'd1; mode = 2'd2; start = 1'b1;
    exp_q.push_back('{1'b1, c0 + 27});
    for (int k = 1; k <= 29; k++) begin
      @(negedge clock);
      start = 1'b0;
      er = (k <= 12) ? exp_rem(k, 1'b1, 3) : (k <= 18) ? 3 : exp_rem(k - 6, 1'b1, 3);
      checks++;
      if (paused !== 1'(k >= 13 && k <= 17) || water_intake !== 1'(k <= 8)) begin
        errors++;
        $display("FAIL pause_flags k=%0d paused=%0b water=%0b", k, paused, water_intake);
      end
      checks++;
      if (busy !== 1'(k <= 26)) begin
        errors++; $display("FAIL pause_busy k=%0d got %0b want %0b", k, busy, k <= 26);
      end
      checks++;
      if (int'(remaining) !== er) begin
        errors++; $display("FAIL pause_remaining k=%0d got %0d want %0d", k, remaining, er);
      end
      lid = (k >= 12 && k <= 16);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL pause_pending got %0d want 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_heavy_and_saturate();
    int c0;
    @(negedge clock);
    c0 = cyc; phase = 2'd1; mode = 2'd3; start = 1'b1; s_start = 1'b1;
    exp_q.push_back('{1'b1, c0 + 33});
    for (int k = 1; k <= 35; k++) begin
      @(negedge clock);
      start = 1'b0; s_start = 1'b0;
      checks++;
      if (int'(remaining) !== exp_rem(k, 1'b1, 6)) begin
        errors++;
        $display("FAIL heavy_remaining k=%0d got %0d want %0d", k, remaining, exp_rem(k, 1'b1, 6));
      end
      if (k == 9) begin
        checks++;
        if (int'(s_remaining) !== int'(SAT)) begin
          errors++; $display("FAIL sat_remaining got %0d want %0d", s_remaining, SAT);
        end
      end
    end
    cancel = 1'b1;
    @(negedge clock);
    cancel = 1'b0;
    checks++;
    if (s_aborted !== 1'b1 || s_busy !== 1'b0) begin
      errors++; $display("FAIL sat_cancel aborted=%0b busy=%0b want 1 0", s_aborted, s_busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL heavy_pending got %0d want 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_cancel();
    int c0;
    @(negedge clock);
    c0 = cyc; phase = 2'd1; mode = 2'd2; start = 1'b1;
    exp_q.push_back('{1'b0, c0 + 11});
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      start = 1'b0; cancel = 1'b0;
      checks++;
      if (busy !== 1'(k <= 10)) begin
        errors++; $display("FAIL cancel_busy k=%0d got %0b want %0b", k, busy, k <= 10);
      end
      if (k == 11) begin
        checks++;
        if (remaining !== '0 || water_intake !== 1'b0 || paused !== 1'b0) begin
          errors++;
          $display("FAIL cancel_clear rem=%0d water=%0b paused=%0b want 0 0 0",
                   remaining, water_intake, paused);
        end
      end
      if (k == 10) cancel = 1'b1;
    end
    @(negedge clock);
    c0 = cyc; start = 1'b1;
    exp_q.push_back('{1'b0, c0 + 6});
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      start = 1'b0; lid = 1'b0; cancel = 1'b0;
      checks++;
      if (paused !== 1'b0 || busy !== 1'(k <= 5)) begin
        errors++; $display("FAIL cancel_lid k=%0d paused=%0b busy=%0b want 0 %0b", k, paused, busy, k <= 5);
      end
      if (k == 5) begin
        lid = 1'b1; cancel = 1'b1;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL cancel_pending got %0d want 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_ignored_starts();
    int c0;
    for (int t = 0; t < 2; t++) begin
      @(negedge clock);
      phase = 2'd3; mode = 2'd2; start = 1'b1; lid = (t == 0); cancel = (t == 1);
      for (int k = 1; k <= 3; k++) begin
        @(negedge clock);
        start = 1'b0; lid = 1'b0; cancel = 1'b0;
        checks++;
        if (busy !== 1'b0 || remaining !== '0) begin
          errors++; $display("FAIL blocked_start t=%0d k=%0d busy=%0b rem=%0d want 0 0", t, k, busy, remaining);
        end
      end
    end
    @(negedge clock);
    c0 = cyc; phase = 2'd1; mode = 2'd0; start = 1'b1;
    exp_q.push_back('{1'b1, c0 + 21});
    for (int k = 1; k <= 25; k++) begin
      @(negedge clock);
      start = 1'b0;
      checks++;
      if (busy !== 1'(k <= 20)) begin
        errors++; $display("FAIL restart_busy k=%0d got %0b want %0b", k, busy, k <= 20);
      end
      if (k == 5 || k == 21) begin
        phase = 2'd3; mode = 2'd2; start = 1'b1;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL restart_pending got %0d want 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_run();
    int c0;
    @(negedge clock);
    phase = 2'd3; mode = 2'd2; start = 1'b1;
    repeat (5) begin
      @(negedge clock);
      start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, aborted, paused, water_intake} !== 5'b0 || remaining !== '0) begin
      errors++;
      $display("FAIL midrun_reset got %b rem=%0d want 00000 rem=0",
               {busy, done, aborted, paused, water_intake}, remaining);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    c0 = cyc; phase = 2'd3; start = 1'b1;
    exp_q.push_back('{1'b1, c0 + 9});
    repeat (11) begin
      @(negedge clock);
      start = 1'b0;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL midrun_pending got %0d want 0", exp_q.size()); exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_wash_fill();
    test_spin_and_zero();
    test_pause();
    test_heavy_and_saturate();
    test_cancel();
    test_ignored_starts();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
